// File: rtl/lh_digest_hex_tx.sv
// rtl/lh_digest_hex_tx.sv - streams each captured 64-bit digest as lowercase ASCII hex over valid/ready
// Optional feature: LH_HEX_STRIP_ZEROS_EN skips leading zero nibbles.
module lh_digest_hex_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] digest,
    input  logic        digest_ready,
    output logic [7:0]  char_byte,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        char_last,
    output logic        busy,
    output logic        err_digest_overrun
);

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rdy_q;
    logic [63:0] r_active;
    logic [3:0]  r_idx;
    logic [63:0] r_pend;
    logic        r_pend_vld;
    logic        r_err;

    logic        w_edge;
    logic        w_xfer;
    logic        w_last_xfer;
    logic        w_load_digest;
    logic        w_load_pend;
    logic        w_store_pend;
    logic        w_clear_pend;
    logic        w_overrun;
    logic [3:0]  w_start_digest;
    logic [3:0]  w_start_pend;
    logic [3:0]  w_nib;

`ifdef LH_HEX_STRIP_ZEROS_EN
    // Index of the highest non-zero nibble; an all-zero digest still emits one '0'.
    function automatic logic [3:0] start_idx(input logic [63:0] d);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (d[i*4 +: 4] != 4'h0) idx = 4'(i);
        end
        return idx;
    endfunction

    assign w_start_digest = start_idx(digest);
    assign w_start_pend   = start_idx(r_pend);
`else
    assign w_start_digest = 4'hf;
    assign w_start_pend   = 4'hf;
`endif

    assign w_edge      = digest_ready & ~r_rdy_q;
    assign w_xfer      = (r_state == S_SEND) & char_ready;
    assign w_last_xfer = w_xfer & (r_idx == 4'd0);

    always_comb begin
        w_state_nxt   = r_state;
        w_load_digest = 1'b0;
        w_load_pend   = 1'b0;
        w_store_pend  = 1'b0;
        w_clear_pend  = 1'b0;
        w_overrun     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_load_digest = 1'b1;
                    w_state_nxt   = S_SEND;
                end
            end
            S_SEND: begin
                if (w_last_xfer) begin
                    if (r_pend_vld) begin
                        w_load_pend = 1'b1;
                        // Slot is vacated and refilled in the same cycle, so no overrun here.
                        if (w_edge) w_store_pend = 1'b1;
                        else        w_clear_pend = 1'b1;
                    end else if (w_edge) begin
                        w_load_digest = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_edge) begin
                    if (!r_pend_vld) w_store_pend = 1'b1;
                    else             w_overrun    = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_q    <= 1'b1;
            r_err      <= 1'b0;
            r_active   <= 64'd0;
            r_idx      <= 4'd0;
            r_pend     <= 64'd0;
            r_pend_vld <= 1'b0;
        end else begin
            r_rdy_q <= digest_ready;
            r_err   <= w_overrun;
            if (w_load_digest) begin
                r_active <= digest;
                r_idx    <= w_start_digest;
            end else if (w_load_pend) begin
                r_active <= r_pend;
                r_idx    <= w_start_pend;
            end else if (w_xfer) begin
                r_idx <= r_idx - 4'd1;
            end
            if (w_store_pend) begin
                r_pend     <= digest;
                r_pend_vld <= 1'b1;
            end else if (w_clear_pend) begin
                r_pend_vld <= 1'b0;
            end
        end
    end

    assign w_nib = r_active[{r_idx, 2'b00} +: 4];

    always_comb begin
        char_byte = 8'h00;
        if (r_state == S_SEND) begin
            if (w_nib < 4'd10) char_byte = 8'h30 + {4'h0, w_nib};
            else               char_byte = 8'h57 + {4'h0, w_nib};
        end
    end

    assign char_valid         = (r_state == S_SEND);
    assign char_last          = (r_state == S_SEND) & (r_idx == 4'd0);
    assign busy               = (r_state == S_SEND) | r_pend_vld;
    assign err_digest_overrun = r_err;

endmodule

// File: tb/tb_lh_digest_hex_tx.sv
// tb/tb_lh_digest_hex_tx.sv - directed self-checking bench for lh_digest_hex_tx
module tb_lh_digest_hex_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] digest;
    logic        digest_ready;
    logic [7:0]  char_byte;
    logic        char_valid;
    logic        char_ready;
    logic        char_last;
    logic        busy;
    logic        err_digest_overrun;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int stall_viol;

    logic [7:0] rx_q[$];
    bit         rx_last[$];
    int         rx_cyc[$];

    localparam logic [63:0] DA = 64'hdcdfac61d4981831;
    localparam logic [63:0] DB = 64'h1abaa6f939b1cb79;
    localparam logic [63:0] DC = 64'h0123456789abcdef;
    localparam logic [63:0] DD = 64'hfedcba9876543210;

    lh_digest_hex_tx dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .digest             (digest),
        .digest_ready       (digest_ready),
        .char_byte          (char_byte),
        .char_valid         (char_valid),
        .char_ready         (char_ready),
        .char_last          (char_last),
        .busy               (busy),
        .err_digest_overrun (err_digest_overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (err_digest_overrun === 1'b1) err_cnt++;

    // Collects up to n characters; pads short results so later indexing stays in range.
    task automatic capture(input int n, input int budget, input bit toggle);
        int         cyc = 0;
        bit         stalled = 0;
        logic [7:0] held = 8'h00;
        rx_q.delete();
        rx_last.delete();
        rx_cyc.delete();
        stall_viol = 0;
        while (rx_q.size() < n && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (stalled && (char_valid !== 1'b1 || char_byte !== held)) stall_viol++;
            char_ready = toggle ? cyc[0] : 1'b1;
            stalled = 0;
            if (char_valid === 1'b1) begin
                if (char_ready) begin
                    rx_q.push_back(char_byte);
                    rx_last.push_back(char_last);
                    rx_cyc.push_back(cyc);
                end else begin
                    stalled = 1;
                    held    = char_byte;
                end
            end
        end
        char_ready = 1'b1;
        while (rx_q.size() < n) begin
            rx_q.push_back(8'h00);
            rx_last.push_back(1'b0);
            rx_cyc.push_back(-1);
        end
    endtask

    function automatic string rx_str();
        string s = "";
        foreach (rx_q[i]) s = {s, $sformatf("%c", rx_q[i])};
        return s;
    endfunction

    function automatic int last_cnt();
        int c = 0;
        foreach (rx_last[i]) if (rx_last[i]) c++;
        return c;
    endfunction

    task automatic test_reset;
        rst_n        = 1'b0;
        digest       = DA;
        digest_ready = 1'b1;
        char_ready   = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({char_byte, char_valid, char_last, busy, err_digest_overrun} !== 12'h000) begin
            failures++;
            $display("FAIL reset_outputs got byte=%h v=%b l=%b busy=%b err=%b want all zero",
                     char_byte, char_valid, char_last, busy, err_digest_overrun);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (char_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL level_at_release got valid=%b busy=%b want 0 0", char_valid, busy);
        end
        digest_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        digest       = DA;
        digest_ready = 1'b1;
        capture(16, 40, 1'b0);
        digest_ready = 1'b0;
        checks++;
        if (rx_str() != "dcdfac61d4981831") begin
            failures++;
            $display("FAIL basic_string got \"%s\" want \"dcdfac61d4981831\"", rx_str());
        end
        checks++;
        if (rx_q[0] !== 8'h64 || rx_cyc[0] != 1) begin
            failures++;
            $display("FAIL basic_latency got byte=%h cycle=%0d want 64 cycle 1", rx_q[0], rx_cyc[0]);
        end
        checks++;
        if (rx_cyc[15] != 16 || rx_last[15] !== 1'b1 || last_cnt() != 1 || rx_q[15] !== 8'h31) begin
            failures++;
            $display("FAIL basic_last got cyc=%0d last=%b nlast=%0d byte=%h want 16 1 1 31",
                     rx_cyc[15], rx_last[15], last_cnt(), rx_q[15]);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || char_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_idle got busy=%b valid=%b want 0 0", busy, char_valid);
        end
    endtask

    task automatic test_backpressure;
        digest       = DB;
        digest_ready = 1'b1;
        capture(16, 80, 1'b1);
        digest_ready = 1'b0;
        checks++;
        if (rx_str() != "1abaa6f939b1cb79") begin
            failures++;
            $display("FAIL bp_string got \"%s\" want \"1abaa6f939b1cb79\"", rx_str());
        end
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL bp_hold got violations=%0d want 0", stall_viol);
        end
        checks++;
        if (last_cnt() != 1 || rx_last[15] !== 1'b1) begin
            failures++;
            $display("FAIL bp_last got nlast=%0d last15=%b want 1 1", last_cnt(), rx_last[15]);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_overrun;
        err_cnt      = 0;
        digest       = DA;
        digest_ready = 1'b1;
        fork
            capture(32, 80, 1'b0);
            begin
                @(negedge clk); digest_ready = 1'b0;
                @(negedge clk); digest = DB; digest_ready = 1'b1;
                @(negedge clk); digest_ready = 1'b0;
                @(negedge clk); digest = DC; digest_ready = 1'b1;
                @(negedge clk); digest_ready = 1'b0;
            end
        join
        checks++;
        if (rx_str() != "dcdfac61d49818311abaa6f939b1cb79") begin
            failures++;
            $display("FAIL ovr_string got \"%s\" want A then B", rx_str());
        end
        checks++;
        if (rx_cyc[31] != 32 || rx_last[15] !== 1'b1 || rx_last[31] !== 1'b1 || last_cnt() != 2) begin
            failures++;
            $display("FAIL ovr_timing got cyc31=%0d nlast=%0d want 32 2", rx_cyc[31], last_cnt());
        end
        @(negedge clk);
        checks++;
        if (err_cnt != 1) begin
            failures++;
            $display("FAIL ovr_err got pulses=%0d want 1", err_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ovr_dropped got busy=%b want 0", busy);
        end
    endtask

    task automatic test_boundary;
        err_cnt      = 0;
        digest       = DA;
        digest_ready = 1'b1;
        fork
            capture(48, 100, 1'b0);
            begin
                @(negedge clk); digest_ready = 1'b0;
                @(negedge clk); digest = DB; digest_ready = 1'b1;
                @(negedge clk); digest_ready = 1'b0;
                repeat (13) @(negedge clk);
                digest = DD; digest_ready = 1'b1;
                @(negedge clk); digest_ready = 1'b0;
            end
        join
        checks++;
        if (rx_str() != "dcdfac61d49818311abaa6f939b1cb79fedcba9876543210") begin
            failures++;
            $display("FAIL bnd_string got \"%s\" want A B D", rx_str());
        end
        checks++;
        if (rx_cyc[47] != 48 || last_cnt() != 3) begin
            failures++;
            $display("FAIL bnd_timing got cyc47=%0d nlast=%0d want 48 3", rx_cyc[47], last_cnt());
        end
        @(negedge clk);
        checks++;
        if (err_cnt != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bnd_err got pulses=%0d busy=%b want 0 0", err_cnt, busy);
        end
    endtask

    task automatic test_strip;
        string exp_a;
        string exp_z;
        int    n_a;
        int    n_z;
`ifdef LH_HEX_STRIP_ZEROS_EN
        exp_a = "abcd";             n_a = 4;
        exp_z = "0";                n_z = 1;
`else
        exp_a = "000000000000abcd"; n_a = 16;
        exp_z = "0000000000000000"; n_z = 16;
`endif
        digest       = 64'h000000000000abcd;
        digest_ready = 1'b1;
        capture(n_a, 40, 1'b0);
        digest_ready = 1'b0;
        checks++;
        if (rx_str() != exp_a || rx_cyc[0] != 1 || rx_last[n_a-1] !== 1'b1 || last_cnt() != 1) begin
            failures++;
            $display("FAIL strip_abcd got \"%s\" cyc0=%0d want \"%s\" cyc 1", rx_str(), rx_cyc[0], exp_a);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL strip_extra got busy=%b want 0", busy);
        end
        digest       = 64'd0;
        digest_ready = 1'b1;
        capture(n_z, 40, 1'b0);
        digest_ready = 1'b0;
        checks++;
        if (rx_str() != exp_z || rx_last[n_z-1] !== 1'b1 || last_cnt() != 1) begin
            failures++;
            $display("FAIL strip_zero got \"%s\" nlast=%0d want \"%s\"", rx_str(), last_cnt(), exp_z);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int spurious = 0;
        digest       = DA;
        digest_ready = 1'b1;
        capture(4, 20, 1'b0);
        @(negedge clk);
        checks++;
        if (char_valid !== 1'b1 || char_byte !== 8'h61) begin
            failures++;
            $display("FAIL mid_fifth got valid=%b byte=%h want 1 61", char_valid, char_byte);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (char_valid !== 1'b0 || busy !== 1'b0 || char_byte !== 8'h00) begin
            failures++;
            $display("FAIL mid_async got valid=%b busy=%b byte=%h want 0 0 00", char_valid, busy, char_byte);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (char_valid !== 1'b0) spurious++;
        end
        checks++;
        if (spurious != 0) begin
            failures++;
            $display("FAIL mid_resume got valid_cycles=%0d want 0", spurious);
        end
        digest_ready = 1'b0;
        @(negedge clk);
        digest_ready = 1'b1;
        capture(16, 40, 1'b0);
        digest_ready = 1'b0;
        checks++;
        if (rx_str() != "dcdfac61d4981831" || rx_cyc[0] != 1) begin
            failures++;
            $display("FAIL mid_restart got \"%s\" cyc0=%0d want full A at 1", rx_str(), rx_cyc[0]);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_overrun();
        test_boundary();
        test_strip();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lh_digest_hex_tx.md
# lh_digest_hex_tx

Downstream companion of `light_hash`: captures each finished 64-bit digest when `digest_ready` rises and streams it out as 16 ASCII hex characters over a valid/ready byte interface. Characters go most-significant nibble first. Feeds a UART/console/log sink so digests can be compared as text, e.g. "dcdfac61d4981831". Holds one pending digest so back-to-back hashes are not lost while a previous one is still draining.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `digest`  in  64  digest from `light_hash`; sampled only on a `digest_ready` rising edge
- `digest_ready`  in  1  level from `light_hash`; a 0→1 transition marks a new digest
- `char_byte`  out  8  ASCII hex character, lowercase: '0'-'9' = 0x30-0x39, 'a'-'f' = 0x61-0x66
- `char_valid`  out  1  `char_byte` is valid
- `char_ready`  in  1  sink accepts the character
- `char_last`  out  1  current character is the last of this digest
- `busy`  out  1  a digest is being sent or is pending
- `err_digest_overrun`  out  1  one-cycle pulse: a digest was dropped because the pending slot was full

## Operation
- **Edge detect:** `rdy_q` register holds the previous `digest_ready`; it resets to 1. An edge is `digest_ready & ~rdy_q`. A level already high at reset release is not an edge.
- **FSM states:** IDLE and SEND.
  - IDLE + edge → load `digest` into the active register, set the nibble index, go to SEND.
  - SEND + transfer on the last character → if a digest is pending, load it and stay in SEND; otherwise go to IDLE.
- **Nibble index:** 4-bit counter. Starts at 15 (bits [63:60]) and decrements on each transfer. The last character is at index 0.
- **Hex conversion:** combinational from the active register.
  - nibble < 10 → 0x30 + nibble
  - nibble ≥ 10 → 0x57 + nibble
- **Transfer:** a character transfers when `char_valid` & `char_ready` at a rising edge.
- **Pending slot:** one-deep register plus a valid flag.
  - Edge in SEND with the slot empty → digest stored in the slot.
  - Edge in SEND with the slot full → new digest dropped, the older pending digest kept, `err_digest_overrun` = 1 for one cycle.
  - Edge on the same cycle as the last-character transfer with the slot full → pending moves to active and the new digest enters the slot. No error.
  - Edge on the same cycle as the last-character transfer with the slot empty → the new digest becomes active directly.
- **`busy`:** (state == SEND) | pending valid.

## Timing
- **Reset values:** `char_byte` = 0x00, `char_valid` = 0, `char_last` = 0, `busy` = 0, `err_digest_overrun` = 0, state = IDLE, pending empty, `rdy_q` = 1.
- **Reset mid-stream:** `rst_n` low clears everything immediately (asynchronous). The partial digest is abandoned and nothing resumes after release.
- **Latency:** edge sampled at clock edge N → `char_valid` = 1 with the first character during cycle N+1.
- **Throughput:** one character per cycle while `char_ready` = 1. 16 characters occupy exactly 16 cycles. A pending digest follows with no bubble.
- **Handshake rules:**
  - `char_valid` does not drop and `char_byte`/`char_last` do not change until the transfer completes.
  - `char_valid` does not depend combinationally on `char_ready`.
- `err_digest_overrun` is registered and asserts the cycle after the dropping edge.

## Configuration
- **`LH_HEX_STRIP_ZEROS_EN` defined:** leading zero nibbles are skipped, matching the `%0h` formatting.
  - At load, the start index = position of the highest non-zero nibble.
  - An all-zero digest emits the single character '0' with `char_last` = 1.
  - Latency to the first character is unchanged.
- **Not defined:** always 16 characters, including leading zeros.

## Test plan
- **Basic stream:** reset; `digest` = 64'hdcdfac61d4981831, raise `digest_ready`, `char_ready` = 1 → 16 consecutive transfers spelling "dcdfac61d4981831". First byte 0x64 in cycle N+1; `char_last` only on the final '1' (0x31); then `busy` = 0.
- **Backpressure:** digest 64'h1abaa6f939b1cb79, `char_ready` toggling 1/0 → `char_byte` held stable during stalls. Full string "1abaa6f939b1cb79" received with no loss or duplication.
- **Overrun:** three edges (digests A, B, C) within the first 16 cycles of A → A then B sent back-to-back (32 characters, no gap). C dropped; `err_digest_overrun` pulses exactly once.
- **Boundary:** edge on the same cycle as A's last transfer with B pending → B sent next, the new digest after it, no error.
- **Macro:** digest 64'h000000000000abcd → "abcd" (4 characters) with `LH_HEX_STRIP_ZEROS_EN`, "000000000000abcd" without. Digest 0 with the macro → "0" with `char_last`.
- **Reset mid-stream:** assert `rst_n` low during the 5th character → `char_valid` = 0 immediately. After release with `digest_ready` still high, no output until `digest_ready` falls and rises again.
